// File: rtl/rf_cmd_pkg.sv
// Shared definitions for the register-file command deframer: header opcodes,
// header bit positions, FSM state encoding and a counter-width helper.
package rf_cmd_pkg;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    localparam int unsigned HDR_OP_MSB = 7;
    localparam int unsigned HDR_OP_LSB = 6;

    typedef enum logic [2:0] {
        StIdle,
        StPayload,
        StIssue,
        StWaitRsp,
        StSend
    } state_e;

    // Bits needed to count 0..n-1; never returns 0 so a counter always exists.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rf_byte_serializer.sv
// Parallel-load word to MSB-first byte stream with valid/ready flow control.
// done_o pulses in the cycle the final byte is handed off.
module rf_byte_serializer
    import rf_cmd_pkg::*;
#(
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] load_data_i,
    output logic [7:0]        out_byte_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              done_o
);

    localparam int unsigned NB = DATA_W / 8;
    localparam int unsigned CW = cnt_width(NB);

    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic              fire;
    logic              last;

    assign fire        = valid_q & out_ready_i;
    assign last        = (cnt_q == CW'(NB - 1));
    assign out_byte_o  = shift_q[DATA_W-1 -: 8];
    assign out_valid_o = valid_q;
    assign done_o      = fire & last;

    // Next state: load wins; otherwise each accepted byte shifts the word up.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (load_i) begin
            shift_d = load_data_i;
            cnt_d   = '0;
            valid_d = 1'b1;
        end else if (fire) begin
            shift_d = shift_q << 8;
            if (last) begin
                cnt_d   = '0;
                valid_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/rf_cmd_deframer.sv
// Byte-stream command deframer for the 32x64 register file. Parses WRITE/READ
// frames into register-file requests and streams READ data back MSB first.
module rf_cmd_deframer
    import rf_cmd_pkg::*;
#(
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        in_byte_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic              req_valid_o,
    input  logic              req_ready_i,
    output logic              req_we_o,
    output logic [ADDR_W-1:0] req_addr_o,
    output logic [DATA_W-1:0] req_wdata_o,
    input  logic              rsp_valid_i,
    input  logic [DATA_W-1:0] rsp_data_i,
    output logic [7:0]        out_byte_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              err_o
);

    localparam int unsigned NB  = DATA_W / 8;
    localparam int unsigned PCW = cnt_width(NB);
    localparam int unsigned TCW = cnt_width(TIMEOUT_CYC + 1);

    state_e            state_q;
    logic              in_ready_q;
    logic              req_valid_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [PCW-1:0]    pcnt_q;
    logic [TCW-1:0]    idle_q;
    logic              err_q;

    logic              in_fire;
    logic [1:0]        hdr_op;
    logic [ADDR_W-1:0] hdr_addr;
    logic [TCW-1:0]    idle_nxt;
    logic              timeout_hit;
    logic              ser_load;
    logic              ser_done;

    assign in_fire  = in_valid_i & in_ready_q;
    assign hdr_op   = in_byte_i[HDR_OP_MSB:HDR_OP_LSB];
    assign hdr_addr = in_byte_i[ADDR_W-1:0];

    // Idle counter saturates so it can never wrap back to an early value.
    assign idle_nxt    = (idle_q == '1) ? idle_q : idle_q + 1'b1;
    assign timeout_hit = (TIMEOUT_CYC != 0) && (idle_nxt == TCW'(TIMEOUT_CYC));

    // Response capture happens on the same edge the FSM leaves WAIT_RSP.
    assign ser_load = (state_q == StWaitRsp) & rsp_valid_i;

    assign in_ready_o  = in_ready_q;
    assign req_valid_o = req_valid_q;
    assign req_we_o    = we_q;
    assign req_addr_o  = addr_q;
    assign req_wdata_o = wdata_q;
    assign err_o       = err_q;

    // Deframer FSM with payload shifter, idle timeout and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            in_ready_q  <= 1'b1;
            req_valid_q <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            pcnt_q      <= '0;
            idle_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_fire) begin
                        unique case (hdr_op)
                            OP_WRITE: begin
                                we_q    <= 1'b1;
                                addr_q  <= hdr_addr;
                                pcnt_q  <= '0;
                                idle_q  <= '0;
                                state_q <= StPayload;
                            end
                            OP_READ: begin
                                we_q        <= 1'b0;
                                addr_q      <= hdr_addr;
                                req_valid_q <= 1'b1;
                                in_ready_q  <= 1'b0;
                                state_q     <= StIssue;
                            end
                            OP_RSVD: err_q <= 1'b1;
                            default: ;
                        endcase
                    end
                end
                StPayload: begin
                    if (in_fire) begin
                        wdata_q <= (wdata_q << 8) | DATA_W'(in_byte_i);
                        idle_q  <= '0;
                        if (pcnt_q == PCW'(NB - 1)) begin
                            pcnt_q      <= '0;
                            req_valid_q <= 1'b1;
                            in_ready_q  <= 1'b0;
                            state_q     <= StIssue;
                        end else begin
                            pcnt_q <= pcnt_q + 1'b1;
                        end
                    end else if (timeout_hit) begin
                        // Abandon the partial frame; stale wdata is overwritten by the next WRITE.
                        err_q   <= 1'b1;
                        idle_q  <= '0;
                        pcnt_q  <= '0;
                        state_q <= StIdle;
                    end else begin
                        idle_q <= idle_nxt;
                    end
                end
                StIssue: begin
                    if (req_ready_i) begin
                        req_valid_q <= 1'b0;
                        if (we_q) begin
                            in_ready_q <= 1'b1;
                            state_q    <= StIdle;
                        end else begin
                            state_q <= StWaitRsp;
                        end
                    end
                end
                StWaitRsp: begin
                    if (rsp_valid_i) state_q <= StSend;
                end
                StSend: begin
                    if (ser_done) begin
                        in_ready_q <= 1'b1;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    rf_byte_serializer #(
        .DATA_W (DATA_W)
    ) u_ser (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (ser_load),
        .load_data_i (rsp_data_i),
        .out_byte_o  (out_byte_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .done_o      (ser_done)
    );

endmodule

// File: tb/tb_rf_cmd_deframer.sv
// Self-checking bench: transaction-level model of requests, register contents
// and response bytes, compared against the DUT every cycle.
module tb_rf_cmd_deframer;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned TO     = 16;
    localparam int unsigned NB     = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        in_byte = 8'h00;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic [7:0]        out_byte;
    logic              out_valid;
    logic              out_ready;
    logic              err;

    always #5 clk = ~clk;

    rf_cmd_deframer #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_byte_i   (in_byte),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .req_valid_o (req_valid),
        .req_ready_i (req_ready),
        .req_we_o    (req_we),
        .req_addr_o  (req_addr),
        .req_wdata_o (req_wdata),
        .rsp_valid_i (rsp_valid),
        .rsp_data_i  (rsp_data),
        .out_byte_o  (out_byte),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .err_o       (err)
    );

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [63:0] wdata;
    } req_t;

    req_t        exp_req[$];
    logic [7:0]  exp_bytes[$];
    logic [7:0]  out_log[$];
    logic [63:0] rf[32];
    logic [63:0] mdl[32];

    int          total = 0;
    int          bad = 0;
    logic        err_exp = 1'b0;
    int          req_cnt = 0;
    int          out_cnt = 0;
    logic        last_we = 1'b0;
    logic [4:0]  last_addr = '0;
    logic [63:0] last_wdata = '0;
    bit          hold_req = 1'b0;
    bit          force_ready = 1'b0;
    int          rsp_delay_fixed = 0;

    // Responder / monitor state.
    bit          req_stall = 1'b0;
    bit          out_stall = 1'b0;
    int          rsp_cnt = 0;
    logic [4:0]  rsp_addr = '0;
    req_t        s_req;
    logic [7:0]  s_ob = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        total++;
        bad++;
        $display("FAIL %s: got an event, want none", name);
    endtask

    // Register-file responder plus per-cycle output checker.
    initial begin : resp
        req_t e;
        logic [7:0] eb;
        req_ready = 1'b0;
        out_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rsp_cnt   = 0;
                req_stall = 1'b0;
                out_stall = 1'b0;
            end else begin
                chk("err", err, err_exp);
                if (req_stall) begin
                    chk("req_held", req_valid, 1);
                    chk("req_we_stable", req_we, s_req.we);
                    chk("req_addr_stable", req_addr, s_req.addr);
                    chk("req_wdata_stable", req_wdata, s_req.wdata);
                end
                req_stall = 1'b0;
                if (req_valid) begin
                    chk("in_ready_in_issue", in_ready, 0);
                    if (req_ready) begin
                        if (exp_req.size() == 0) begin
                            unexpected("unexpected_req");
                        end else begin
                            e = exp_req.pop_front();
                            chk("req_we", req_we, e.we);
                            chk("req_addr", req_addr, e.addr);
                            if (e.we) chk("req_wdata", req_wdata, e.wdata);
                        end
                        last_we    = req_we;
                        last_addr  = req_addr;
                        last_wdata = req_wdata;
                        req_cnt++;
                        if (req_we) begin
                            rf[req_addr] = req_wdata;
                        end else begin
                            rsp_addr = req_addr;
                            rsp_cnt  = (rsp_delay_fixed > 0) ? rsp_delay_fixed
                                                             : int'($urandom_range(1, 3));
                        end
                    end else begin
                        req_stall   = 1'b1;
                        s_req.we    = req_we;
                        s_req.addr  = req_addr;
                        s_req.wdata = req_wdata;
                    end
                end
                if (out_stall) begin
                    chk("out_held", out_valid, 1);
                    chk("out_byte_stable", out_byte, s_ob);
                end
                out_stall = 1'b0;
                if (out_valid) begin
                    chk("in_ready_in_send", in_ready, 0);
                    if (out_ready) begin
                        if (exp_bytes.size() == 0) begin
                            unexpected("unexpected_out_byte");
                        end else begin
                            eb = exp_bytes.pop_front();
                            chk("out_byte", out_byte, eb);
                        end
                        out_log.push_back(out_byte);
                        out_cnt++;
                    end else begin
                        out_stall = 1'b1;
                        s_ob      = out_byte;
                    end
                end
            end
            @(posedge clk);
            #1;
            req_ready = hold_req ? 1'b0 : (force_ready ? 1'b1 : 1'($urandom_range(0, 1)));
            out_ready = force_ready ? 1'b1 : ($urandom_range(0, 2) != 0);
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                rsp_valid = (rsp_cnt == 0);
                rsp_data  = (rsp_cnt == 0) ? rf[rsp_addr] : {$urandom, $urandom};
            end else begin
                // Stray responses outside WAIT_RSP must be ignored by the DUT.
                rsp_valid = ($urandom_range(0, 7) == 0);
                rsp_data  = {$urandom, $urandom};
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1);
    end

    task automatic put(input logic [7:0] b, input int gap);
        bit ok = 1'b0;
        in_valid = 1'b0;
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
        in_byte  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("in_accept", ok, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic push_read(input logic [4:0] a);
        exp_req.push_back('{1'b0, a, 64'h0});
        for (int i = NB - 1; i >= 0; i--) exp_bytes.push_back(mdl[a][i*8 +: 8]);
    endtask

    task automatic do_write(input logic [4:0] a, input logic [63:0] d, input int maxgap,
                            input bit b5);
        exp_req.push_back('{1'b1, a, d});
        mdl[a] = d;
        put({2'b01, b5, a}, $urandom_range(0, maxgap));
        for (int i = NB - 1; i >= 0; i--) put(d[i*8 +: 8], $urandom_range(0, maxgap));
    endtask

    task automatic do_read(input logic [4:0] a, input int maxgap, input bit b5);
        push_read(a);
        put({2'b10, b5, a}, $urandom_range(0, maxgap));
    endtask

    task automatic wait_req(input int target);
        int n = 0;
        while (req_cnt < target && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("wait_req", req_cnt >= target, 1);
    endtask

    task automatic wait_out(input int target);
        int n = 0;
        while (out_cnt < target && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("wait_out", out_cnt >= target, 1);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst      = 1'b1;
        exp_req.delete();
        exp_bytes.delete();
        err_exp  = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_req_valid", req_valid, 0);
        chk("rst_req_we", req_we, 0);
        chk("rst_req_addr", req_addr, 0);
        chk("rst_req_wdata", req_wdata, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_byte", out_byte, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
    endtask

    initial begin : main
        int base;
        logic [63:0] word;
        int op;
        for (int i = 0; i < 32; i++) begin
            rf[i]  = {$urandom, $urandom};
            mdl[i] = rf[i];
        end
        do_reset();

        // Basic WRITE, header 0x43.
        force_ready = 1'b1;
        do_write(5'd3, 64'h0102030405060708, 0, 1'b0);
        wait_req(1);
        chk("t1_we", last_we, 1);
        chk("t1_addr", last_addr, 3);
        chk("t1_wdata", last_wdata, 64'h0102030405060708);

        // READ of register 31 (header 0x9F), response 2 cycles late, random stalls.
        force_ready     = 1'b0;
        rf[31]          = 64'hDEADBEEFCAFEF00D;
        mdl[31]         = 64'hDEADBEEFCAFEF00D;
        rsp_delay_fixed = 2;
        base            = out_cnt;
        do_read(5'd31, 0, 1'b0);
        wait_req(2);
        chk("t2_we", last_we, 0);
        chk("t2_addr", last_addr, 31);
        wait_out(base + 8);
        word = '0;
        for (int i = 0; i < 8; i++) word = {word[55:0], out_log[base + i]};
        chk("t2_stream", word, 64'hDEADBEEFCAFEF00D);
        rsp_delay_fixed = 0;

        // Payload stall: header + 3 bytes then silence until the timeout fires.
        put(8'h4A, 0);
        put(8'h11, 0);
        put(8'h22, 0);
        put(8'h33, 0);
        repeat (TO - 1) @(posedge clk);
        #1;
        chk("t4_err_before_limit", err, 0);
        chk("t4_still_accepting", in_ready, 1);
        @(posedge clk);
        #1;
        err_exp = 1'b1;
        chk("t4_err_at_limit", err, 1);
        chk("t4_no_req", req_cnt, 2);
        do_write(5'd10, {$urandom, $urandom}, 3, 1'b1);
        wait_req(3);

        // Reserved opcode, NOP, then a normal WRITE.
        do_reset();
        base = req_cnt;
        put(8'hC5, 0);
        err_exp = 1'b1;
        chk("t3_rsvd_err", err, 1);
        put(8'h00, 1);
        do_write(5'h15, {$urandom, $urandom}, 2, 1'b0);
        wait_req(base + 1);
        chk("t3_one_req", req_cnt, base + 1);

        // Request held off for 10 cycles while the next header waits.
        do_reset();
        hold_req = 1'b1;
        do_write(5'd7, {$urandom, $urandom}, 0, 1'b0);
        base = req_cnt;
        push_read(5'd5);
        in_byte  = 8'h85;
        in_valid = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            chk("t5_req_valid", req_valid, 1);
            chk("t5_in_ready", in_ready, 0);
            chk("t5_no_handshake", req_cnt, base);
        end
        hold_req = 1'b0;
        put(8'h85, 0);
        wait_req(base + 2);
        chk("t5_read_addr", last_addr, 5);

        // Reset in the middle of SEND after 3 bytes, then a clean READ.
        force_ready = 1'b1;
        wait_out(out_cnt + exp_bytes.size());
        base = out_cnt;
        do_read(5'd9, 0, 1'b0);
        for (int n = 0; n < 200 && out_cnt < base + 3; n++) begin
            @(posedge clk);
            #1;
        end
        chk("t6_three_sent", out_cnt, base + 3);
        chk("t6_mid_send", out_valid, 1);
        do_reset();
        force_ready = 1'b0;
        base = out_cnt;
        do_read(5'd9, 1, 1'b1);
        wait_out(base + 8);
        word = '0;
        for (int i = 0; i < 8; i++) word = {word[55:0], out_log[base + i]};
        chk("t6_full_read", word, mdl[9]);

        // Random command mix.
        for (int k = 0; k < 60; k++) begin
            op = $urandom_range(0, 9);
            if (op < 4) begin
                do_write(5'($urandom), {$urandom, $urandom}, 3, 1'($urandom));
            end else if (op < 8) begin
                do_read(5'($urandom), 3, 1'($urandom));
            end else begin
                put({2'b00, 6'($urandom)}, $urandom_range(0, 3));
            end
        end

        for (int n = 0; n < 3000 && (exp_req.size() != 0 || exp_bytes.size() != 0); n++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_req", exp_req.size(), 0);
        chk("drain_bytes", exp_bytes.size(), 0);
        repeat (5) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
